// File: rtl/pll_mdrp_if.sv
// Management DRP-style bus between an initiator and the emulated PLL responder.
// The initiator drives op/inc/wdata; the responder returns read data, lock and config status.
interface pll_mdrp_if;
  logic       mdrp_inc;
  logic [1:0] mdrp_op;
  logic [7:0] mdrp_wdata;
  logic [7:0] mdrp_rdata;
  logic       pll_lock;
  logic [6:0] cfg_code;
  logic       cfg_stb;
  logic       commit_err;

  modport master (
    output mdrp_inc, mdrp_op, mdrp_wdata,
    input  mdrp_rdata, pll_lock, cfg_code, cfg_stb, commit_err
  );

  modport slave (
    input  mdrp_inc, mdrp_op, mdrp_wdata,
    output mdrp_rdata, pll_lock, cfg_code, cfg_stb, commit_err
  );
endinterface

// File: rtl/pll_mdrp_resp.sv
// Emulated PLL management responder: readable/incrementing code register, staged two-step
// commit of a new config code, and a lock FSM that drops lock for LOCK_CYCLES after a commit.
module pll_mdrp_resp #(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [6:0]  INIT_CODE   = 7'h00
) (
  input logic       clk,
  input logic       rst,
  pll_mdrp_if.slave bus
);

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    RELOCK  = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOOP   = 2'b00;
  localparam logic [1:0] OP_WRCODE = 2'b01;
  localparam logic [1:0] OP_RDCODE = 2'b10;
  localparam logic [7:0] CNT_LOAD  = 8'(LOCK_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] code_q, code_d;
  logic [6:0] cfgCode_q, cfgCode_d;
  logic [6:0] shadow_q, shadow_d;
  logic       staged_q, staged_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cfgStb_q, cfgStb_d;
  logic       commitErr_q, commitErr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOCKING;
      cnt_q       <= CNT_LOAD;
      code_q      <= INIT_CODE;
      cfgCode_q   <= INIT_CODE;
      shadow_q    <= 7'h00;
      staged_q    <= 1'b0;
      rdata_q     <= 8'h00;
      cfgStb_q    <= 1'b0;
      commitErr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      cfgCode_q   <= cfgCode_d;
      shadow_q    <= shadow_d;
      staged_q    <= staged_d;
      rdata_q     <= rdata_d;
      cfgStb_q    <= cfgStb_d;
      commitErr_q <= commitErr_d;
    end
  end

  // Bus ops are only honoured while locked; the two unlocked states just count down.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    cfgCode_d   = cfgCode_q;
    shadow_d    = shadow_q;
    staged_d    = staged_q;
    rdata_d     = rdata_q;
    cfgStb_d    = 1'b0;
    commitErr_d = 1'b0;

    unique case (state_q)
      LOCKING, RELOCK: begin
        if (cnt_q == 8'd0) begin
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      LOCKED: begin
        case (bus.mdrp_op)
          OP_RDCODE: begin
            rdata_d = {1'b0, code_q};
            if (bus.mdrp_inc) begin
              code_d = code_q + 7'd1;
            end
          end
          OP_WRCODE: begin
            if (!bus.mdrp_wdata[7]) begin
              shadow_d = bus.mdrp_wdata[6:0];
              staged_d = 1'b1;
            end else begin
              staged_d = 1'b0;
              // A commit must repeat exactly the value that was staged last.
              if (staged_q && (bus.mdrp_wdata[6:0] == shadow_q)) begin
                cfgCode_d = bus.mdrp_wdata[6:0];
                code_d    = bus.mdrp_wdata[6:0];
                cfgStb_d  = 1'b1;
                state_d   = RELOCK;
                cnt_d     = CNT_LOAD;
              end else begin
                commitErr_d = 1'b1;
              end
            end
          end
          OP_NOOP: ;
          default: ;
        endcase
      end
      default: begin
        state_d = LOCKING;
        cnt_d   = CNT_LOAD;
      end
    endcase
  end

  assign bus.mdrp_rdata = rdata_q;
  assign bus.pll_lock   = (state_q == LOCKED);
  assign bus.cfg_code   = cfgCode_q;
  assign bus.cfg_stb    = cfgStb_q;
  assign bus.commit_err = commitErr_q;

endmodule

// File: tb/tb_pll_mdrp_resp.sv
// Directed bench for pll_mdrp_resp: lock timing, read stream with wrap, staged commits,
// ops gated during relock, and reset in the middle of a relock.
module tb_pll_mdrp_resp;

  localparam int unsigned LOCK     = 16;
  localparam logic [1:0]  OP_NOOP  = 2'b00;
  localparam logic [1:0]  OP_WR    = 2'b01;
  localparam logic [1:0]  OP_RD    = 2'b10;
  localparam logic [1:0]  OP_ILL   = 2'b11;

  logic clk;
  logic rst;
  int   vectorCount;
  int   miscompareCount;

  pll_mdrp_if bus ();

  pll_mdrp_resp #(
    .LOCK_CYCLES(LOCK),
    .INIT_CODE  (7'h7D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle, then settle just after the edge so outputs reflect it.
  task automatic applyStimulus(input logic [1:0] op, input logic inc, input logic [7:0] wdata);
    bus.mdrp_op    = op;
    bus.mdrp_inc   = inc;
    bus.mdrp_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Count how many cycles lock stays low; startLow covers cycles already spent in the window.
  task automatic measureLock(input string tag, input int startLow);
    int low;
    low = startLow;
    while (!bus.pll_lock && low < 40) begin
      low++;
      applyStimulus(OP_NOOP, 1'b0, 8'h00);
    end
    checkOutput({tag, "_lowCycles"}, 32'(low), 32'(LOCK));
    checkOutput({tag, "_lockHigh"}, 32'(bus.pll_lock), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rdata"}, 32'(bus.mdrp_rdata), 32'h00);
    checkOutput({tag, "_lock"}, 32'(bus.pll_lock), 32'd0);
    checkOutput({tag, "_cfgCode"}, 32'(bus.cfg_code), 32'h7D);
    checkOutput({tag, "_cfgStb"}, 32'(bus.cfg_stb), 32'd0);
    checkOutput({tag, "_commitErr"}, 32'(bus.commit_err), 32'd0);
  endtask

  initial begin
    logic [7:0] readStream [6];
    readStream[0] = 8'h7D; readStream[1] = 8'h7E; readStream[2] = 8'h7F;
    readStream[3] = 8'h00; readStream[4] = 8'h01; readStream[5] = 8'h02;
    vectorCount     = 0;
    miscompareCount = 0;

    rst = 1'b1;
    applyStimulus(OP_RD, 1'b1, 8'hA5);
    applyStimulus(OP_RD, 1'b1, 8'hA5);
    checkResetState("reset");
    rst = 1'b0;
    measureLock("resetLock", 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_NOOP, 1'b0, 8'h00);
      checkOutput("lockHolds", 32'(bus.pll_lock), 32'd1);
    end

    // Read stream from 7D wraps through 7F to 00.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(OP_RD, 1'b1, 8'h00);
      checkOutput($sformatf("readStream%0d", i), 32'(bus.mdrp_rdata), 32'(readStream[i]));
    end
    applyStimulus(OP_RD, 1'b0, 8'h00);
    checkOutput("codeAfterStream", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_ILL, 1'b1, 8'h00);
    checkOutput("illegalHoldsRdata", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_NOOP, 1'b1, 8'h00);
    checkOutput("noopHoldsRdata", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_RD, 1'b0, 8'h00);
    checkOutput("incIgnored", 32'(bus.mdrp_rdata), 32'h03);

    // Commits that must be rejected.
    applyStimulus(OP_WR, 1'b0, 8'hA5);
    checkOutput("noStageErr", 32'(bus.commit_err), 32'd1);
    checkOutput("noStageStb", 32'(bus.cfg_stb), 32'd0);
    applyStimulus(OP_NOOP, 1'b0, 8'h00);
    checkOutput("noStageErrPulse", 32'(bus.commit_err), 32'd0);
    checkOutput("noStageCfg", 32'(bus.cfg_code), 32'h7D);
    checkOutput("noStageLock", 32'(bus.pll_lock), 32'd1);
    applyStimulus(OP_WR, 1'b0, 8'h24);
    checkOutput("stageNoErr", 32'(bus.commit_err), 32'd0);
    checkOutput("stageNoRdata", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_WR, 1'b0, 8'hA5);
    checkOutput("mismatchErr", 32'(bus.commit_err), 32'd1);
    checkOutput("mismatchCfg", 32'(bus.cfg_code), 32'h7D);
    checkOutput("mismatchLock", 32'(bus.pll_lock), 32'd1);
    applyStimulus(OP_NOOP, 1'b0, 8'h00);
    checkOutput("mismatchErrPulse", 32'(bus.commit_err), 32'd0);

    // Valid commit, then ops during relock must be ignored.
    applyStimulus(OP_WR, 1'b0, 8'h25);
    applyStimulus(OP_WR, 1'b0, 8'hA5);
    checkOutput("commitStb", 32'(bus.cfg_stb), 32'd1);
    checkOutput("commitCfg", 32'(bus.cfg_code), 32'h25);
    checkOutput("commitLockDrop", 32'(bus.pll_lock), 32'd0);
    checkOutput("commitNoErr", 32'(bus.commit_err), 32'd0);
    applyStimulus(OP_RD, 1'b1, 8'h00);
    checkOutput("relockStbPulse", 32'(bus.cfg_stb), 32'd0);
    checkOutput("relockRdHold", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_RD, 1'b1, 8'h00);
    checkOutput("relockRdHold2", 32'(bus.mdrp_rdata), 32'h03);
    applyStimulus(OP_WR, 1'b0, 8'h30);
    measureLock("relock", 3);
    applyStimulus(OP_WR, 1'b0, 8'hB0);
    checkOutput("staleStageErr", 32'(bus.commit_err), 32'd1);
    checkOutput("staleStageCfg", 32'(bus.cfg_code), 32'h25);
    applyStimulus(OP_RD, 1'b0, 8'h00);
    checkOutput("readAfterCommit", 32'(bus.mdrp_rdata), 32'h25);

    // Last stage wins; then reset lands in the middle of the relock.
    applyStimulus(OP_WR, 1'b0, 8'h10);
    applyStimulus(OP_WR, 1'b0, 8'h11);
    applyStimulus(OP_WR, 1'b0, 8'h91);
    checkOutput("restageStb", 32'(bus.cfg_stb), 32'd1);
    checkOutput("restageCfg", 32'(bus.cfg_code), 32'h11);
    for (int i = 0; i < 3; i++) applyStimulus(OP_NOOP, 1'b0, 8'h00);
    rst = 1'b1;
    applyStimulus(OP_RD, 1'b1, 8'h00);
    checkResetState("midRelockReset");
    rst = 1'b0;
    measureLock("resetRelock", 0);
    applyStimulus(OP_RD, 1'b0, 8'h00);
    checkOutput("codeAfterReset", 32'(bus.mdrp_rdata), 32'h7D);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
